// File: rtl/fsk_mod_tx.sv
`default_nettype none
// ============================================================================
// Module : fsk_mod_tx
// Binary continuous-phase FSK modulator: bit handshake, phase-accumulator NCO,
// quarter-wave sine LUT and a two-stage registered output pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module fsk_mod_tx #(
   parameter int                 PHASE_W         = 32,
   parameter logic [PHASE_W-1:0] F0_WORD         = 32'h0400_0000,
   parameter logic [PHASE_W-1:0] F1_WORD         = 32'h0800_0000,
   parameter int                 SAMPLES_PER_BIT = 128,
   parameter int                 AMP             = 32767
) (
   input  logic               in_clk,
   input  logic               reset,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   output logic signed [15:0] mod_data,
   output logic               mod_valid,
   output logic               tx_busy
);

   localparam int             CNT_W    = $clog2(SAMPLES_PER_BIT);
   localparam logic           c_idle   = 1'b0;
   localparam logic           c_run    = 1'b1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(SAMPLES_PER_BIT - 1);
   localparam longint         c_pi_q30 = 64'sd3373259426;

   // Elaboration-time sine in Q30 fixed point (Taylor series to x^15),
   // giving round(AMP*sin(pi/2*(k+0.5)/64)).
   function automatic logic [14:0] lut_entry(input int k);
      longint x, x2, term, acc;
      x    = (longint'(2 * k + 1) * c_pi_q30) / 256;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 7; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      acc = (longint'(AMP) * acc + (longint'(1) <<< 29)) >>> 30;
      return acc[14:0];
   endfunction

   logic [14:0] lut_rom [64];

   for (genvar gk = 0; gk < 64; gk++) begin : g_lut
      localparam logic [14:0] c_val = lut_entry(gk);
      assign lut_rom[gk] = c_val;
   end

   logic               state_q,     state_d;
   logic               bit_q,       bit_d;
   logic [PHASE_W-1:0] phase_q,     phase_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               a_valid_q,   a_valid_d;
   logic               a_neg_q,     a_neg_d;
   logic [14:0]        a_mag_q,     a_mag_d;
   logic               mod_valid_q, mod_valid_d;
   logic [15:0]        mod_data_q,  mod_data_d;

   logic               at_last;
   logic               hs;
   logic [7:0]         idx;
   logic [5:0]         addr;

   assign at_last = (state_q == c_run) && (cnt_q == c_last);
   assign hs      = bit_valid & bit_ready;

   always_ff @(posedge in_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= c_idle;
         bit_q       <= 1'b0;
         phase_q     <= '0;
         cnt_q       <= '0;
         a_valid_q   <= 1'b0;
         a_neg_q     <= 1'b0;
         a_mag_q     <= '0;
         mod_valid_q <= 1'b0;
         mod_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         a_valid_q   <= a_valid_d;
         a_neg_q     <= a_neg_d;
         a_mag_q     <= a_mag_d;
         mod_valid_q <= mod_valid_d;
         mod_data_q  <= mod_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (state_q)
         c_idle: begin
            phase_d = '0;
            if (hs) begin
               state_d = c_run;
               bit_d   = bit_in;
               cnt_d   = '0;
            end
         end
         default: begin
            phase_d = phase_q + (bit_q ? F1_WORD : F0_WORD);
            cnt_d   = cnt_q + 1'b1;
            // A handshake on the last sample chains the next bit with no gap.
            if (at_last) begin
               cnt_d = '0;
               if (hs) begin
                  bit_d = bit_in;
               end else begin
                  state_d = c_idle;
                  phase_d = '0;
               end
            end
         end
      endcase
   end

   always_comb begin
      bit_ready = (state_q == c_idle) | at_last;
      tx_busy   = (state_q == c_run) | a_valid_q | mod_valid_q;
   end

   // Odd quadrants walk the quarter table backwards: 63-i == ~i.
   always_comb begin
      idx         = phase_q[PHASE_W-1 -: 8];
      addr        = idx[6] ? ~idx[5:0] : idx[5:0];
      a_valid_d   = (state_q == c_run);
      a_neg_d     = idx[7];
      a_mag_d     = lut_rom[addr];
      mod_valid_d = a_valid_q;
      if (!a_valid_q) begin
         mod_data_d = '0;
      end else if (a_neg_q) begin
         mod_data_d = -{1'b0, a_mag_q};
      end else begin
         mod_data_d = {1'b0, a_mag_q};
      end
   end

   assign mod_data  = mod_data_q;
   assign mod_valid = mod_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_mod_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_fsk_mod_tx
// Randomized bench for fsk_mod_tx against an arithmetic phase/sine model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fsk_mod_tx;

   localparam int          SPB = 128;
   localparam int          AMP = 32767;
   localparam logic [31:0] F0  = 32'h0400_0000;
   localparam logic [31:0] F1  = 32'h0800_0000;

   logic               in_clk    = 1'b0;
   logic               reset     = 1'b0;
   logic               bit_in    = 1'b0;
   logic               bit_valid = 1'b0;
   logic               bit_ready;
   logic signed [15:0] mod_data;
   logic               mod_valid;
   logic               tx_busy;

   int total = 0;
   int bad   = 0;

   bit tx_bits   [$];
   int exp_data  [$];
   bit exp_valid [$];
   bit exp_ready [$];
   bit exp_busy  [$];

   always #5 in_clk = ~in_clk;

   fsk_mod_tx dut (
      .in_clk    (in_clk),
      .reset     (reset),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .mod_data  (mod_data),
      .mod_valid (mod_valid),
      .tx_busy   (tx_busy)
   );

   // Full-circle sine at the centre of the 256-step phase bin.
   function automatic int sine_at(input logic [31:0] ph);
      real a, r;
      a = 2.0 * 3.14159265358979 * (real'(int'(ph[31:24])) + 0.5) / 256.0;
      r = real'(AMP) * $sin(a);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   // Timeline indexed by observation t; t=0 is the cycle the first bit is offered.
   task automatic build_model();
      int          n;
      int          last;
      logic [31:0] ph;
      n    = tx_bits.size();
      last = SPB * n + 2;
      ph   = '0;
      exp_data.delete();
      exp_valid.delete();
      exp_ready.delete();
      exp_busy.delete();
      for (int t = 0; t <= last + 3; t++) begin
         exp_valid.push_back(t >= 3 && t <= last);
         exp_busy.push_back(t >= 1 && t <= last);
         exp_ready.push_back(t == 0 || t > SPB * n || (t % SPB) == 0);
         exp_data.push_back(0);
      end
      for (int m = 0; m < SPB * n; m++) begin
         exp_data[m + 3] = sine_at(ph);
         ph = ph + (tx_bits[m / SPB] ? F1 : F0);
      end
   endtask

   task automatic drive_sender(input int t);
      if ((t % SPB) == 0 && (t / SPB) < tx_bits.size()) begin
         bit_valid = 1'b1;
         bit_in    = tx_bits[t / SPB];
      end else begin
         bit_valid = 1'b0;
         bit_in    = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      int n;
      reset     = 1'b0;
      bit_valid = 1'b0;
      repeat (3) begin
         @(negedge in_clk);
         total++;
         if (mod_valid !== 1'b0 || mod_data !== 16'sd0 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold valid=%b data=%0d busy=%b required 0/0/0", mod_valid, mod_data, tx_busy);
         end
      end
      reset = 1'b1;
      n     = 20 + int'($urandom_range(0, 20));
      for (int t = 0; t < n; t++) begin
         @(negedge in_clk);
         total++;
         if (mod_valid !== 1'b0 || mod_data !== 16'sd0 || tx_busy !== 1'b0 || bit_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle t=%0d valid=%b data=%0d busy=%b ready=%b required 0/0/0/1",
                     t, mod_valid, mod_data, tx_busy, bit_ready);
         end
         bit_in = 1'($urandom);
      end
   endtask

   task automatic test_single_bit();
      bit b;
      for (int k = 0; k < 4; k++) begin
         b = (k < 2) ? 1'(k) : 1'($urandom);
         tx_bits.delete();
         tx_bits.push_back(b);
         build_model();
         for (int t = 0; t < exp_valid.size(); t++) begin
            @(negedge in_clk);
            total++;
            if (mod_valid !== exp_valid[t]) begin
               bad++;
               $display("FAIL single_valid bit=%0b t=%0d got=%b required=%b", b, t, mod_valid, exp_valid[t]);
            end
            total++;
            if (mod_data !== 16'(exp_data[t])) begin
               bad++;
               $display("FAIL single_data bit=%0b t=%0d got=%0d required=%0d", b, t, mod_data, exp_data[t]);
            end
            total++;
            if (bit_ready !== exp_ready[t] || tx_busy !== exp_busy[t]) begin
               bad++;
               $display("FAIL single_ctrl bit=%0b t=%0d ready=%b busy=%b required %b/%b",
                        b, t, bit_ready, tx_busy, exp_ready[t], exp_busy[t]);
            end
            drive_sender(t);
         end
      end
   endtask

   task automatic test_back_to_back();
      int len;
      for (int s = 0; s < 3; s++) begin
         tx_bits.delete();
         if (s == 0) begin
            tx_bits.push_back(1'b0);
            tx_bits.push_back(1'b1);
            tx_bits.push_back(1'b0);
         end else begin
            len = int'($urandom_range(2, 4));
            for (int j = 0; j < len; j++) tx_bits.push_back(1'($urandom));
         end
         build_model();
         for (int t = 0; t < exp_valid.size(); t++) begin
            @(negedge in_clk);
            total++;
            if (mod_valid !== exp_valid[t]) begin
               bad++;
               $display("FAIL b2b_valid s=%0d t=%0d got=%b required=%b", s, t, mod_valid, exp_valid[t]);
            end
            total++;
            if (mod_data !== 16'(exp_data[t])) begin
               bad++;
               $display("FAIL b2b_data s=%0d t=%0d got=%0d required=%0d", s, t, mod_data, exp_data[t]);
            end
            total++;
            if (bit_ready !== exp_ready[t] || tx_busy !== exp_busy[t]) begin
               bad++;
               $display("FAIL b2b_ctrl s=%0d t=%0d ready=%b busy=%b required %b/%b",
                        s, t, bit_ready, tx_busy, exp_ready[t], exp_busy[t]);
            end
            drive_sender(t);
         end
      end
   endtask

   task automatic test_ignored_valid();
      tx_bits.delete();
      tx_bits.push_back(1'($urandom));
      build_model();
      for (int t = 0; t < exp_valid.size(); t++) begin
         @(negedge in_clk);
         total++;
         if (mod_valid !== exp_valid[t] || mod_data !== 16'(exp_data[t])) begin
            bad++;
            $display("FAIL ignore_out t=%0d valid=%b data=%0d required %b/%0d",
                     t, mod_valid, mod_data, exp_valid[t], exp_data[t]);
         end
         total++;
         if (bit_ready !== exp_ready[t] || tx_busy !== exp_busy[t]) begin
            bad++;
            $display("FAIL ignore_ctrl t=%0d ready=%b busy=%b required %b/%b",
                     t, bit_ready, tx_busy, exp_ready[t], exp_busy[t]);
         end
         drive_sender(t);
         if (t == 51) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
         end
      end
   endtask

   task automatic test_reset_mid();
      int cut;
      tx_bits.delete();
      tx_bits.push_back(1'b0);
      tx_bits.push_back(1'b1);
      build_model();
      cut = 3 + SPB + 70;
      for (int t = 0; t <= cut; t++) begin
         @(negedge in_clk);
         total++;
         if (mod_valid !== exp_valid[t] || mod_data !== 16'(exp_data[t])) begin
            bad++;
            $display("FAIL midrst_pre t=%0d valid=%b data=%0d required %b/%0d",
                     t, mod_valid, mod_data, exp_valid[t], exp_data[t]);
         end
         drive_sender(t);
      end
      #1 reset = 1'b0;
      #1;
      total++;
      if (mod_valid !== 1'b0 || mod_data !== 16'sd0 || tx_busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async valid=%b data=%0d busy=%b required 0/0/0", mod_valid, mod_data, tx_busy);
      end
      repeat (2) @(negedge in_clk);
      reset = 1'b1;
      tx_bits.delete();
      tx_bits.push_back(1'b0);
      build_model();
      for (int t = 0; t < exp_valid.size(); t++) begin
         @(negedge in_clk);
         total++;
         if (mod_valid !== exp_valid[t] || mod_data !== 16'(exp_data[t])) begin
            bad++;
            $display("FAIL midrst_post t=%0d valid=%b data=%0d required %b/%0d",
                     t, mod_valid, mod_data, exp_valid[t], exp_data[t]);
         end
         total++;
         if (bit_ready !== exp_ready[t] || tx_busy !== exp_busy[t]) begin
            bad++;
            $display("FAIL midrst_ctrl t=%0d ready=%b busy=%b required %b/%b",
                     t, bit_ready, tx_busy, exp_ready[t], exp_busy[t]);
         end
         drive_sender(t);
      end
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_back_to_back();
      test_ignored_valid();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
